// File: rtl/rf_pkg.sv
// rf_pkg: shared register file widths and typedefs
package rf_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write tracking with bypass-masked busy lookup
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_wren_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              iss_valid_i,
    input  logic [ADDR_W-1:0] iss_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i [NUM_RD],
    output logic [NUM_RD-1:0] rs_busy_o
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DEPTH-1:0] busy_q, busy_d;
    // clear on writeback, then set on issue so a newer producer wins; x0 never busy
    always_comb begin
        busy_d = busy_q;
        if (rd_wren_i) busy_d[rd_addr_i] = 1'b0;
        if (iss_valid_i) busy_d[iss_addr_i] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end
    // busy vector register
    always_ff @(posedge clk_i) begin
        if (rst_i) busy_q <= '0;
        else busy_q <= busy_d;
    end
    // a matching same-cycle writeback already forwards the data, so hide its busy
    always_comb begin
        rs_busy_o = '0;
        for (int p = 0; p < NUM_RD; p++)
            rs_busy_o[p] = busy_q[rs_addr_i[p]] &
                ~((BYPASS != 0) && rd_wren_i && (rd_addr_i == rs_addr_i[p]));
    end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with bypass, zero register and scoreboard
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_wren_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              iss_valid_i,
    input  logic [ADDR_W-1:0] iss_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i [NUM_RD],
    output logic [DATA_W-1:0] rs_data_o [NUM_RD],
    output logic [NUM_RD-1:0] rs_busy_o
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    // writeback updates one entry; x0 stays zero when hardwired
    always_comb begin
        mem_d = mem_q;
        if (rd_wren_i && !((ZERO_REG != 0) && (rd_addr_i == '0))) mem_d[rd_addr_i] = rd_data_i;
    end
    // storage register
    always_ff @(posedge clk_i) begin
        if (rst_i) mem_q <= '{default: '0};
        else mem_q <= mem_d;
    end
    // read mux: zero register, then same-cycle forward, then stored value
    always_comb begin
        for (int p = 0; p < NUM_RD; p++)
            rs_data_o[p] = ((ZERO_REG != 0) && (rs_addr_i[p] == '0)) ? '0 :
                ((BYPASS != 0) && rd_wren_i && (rd_addr_i == rs_addr_i[p])) ? rd_data_i :
                mem_q[rs_addr_i[p]];
    end
    rf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_wren_i  (rd_wren_i),
        .rd_addr_i  (rd_addr_i),
        .iss_valid_i(iss_valid_i),
        .iss_addr_i (iss_addr_i),
        .rs_addr_i  (rs_addr_i),
        .rs_busy_o  (rs_busy_o)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed scoreboard bench for a 4-port bypassing and a 2-port plain register file
module tb_reg_file_mp;
    import rf_pkg::*;
    logic clk = 1'b0;
    logic rst, wren, iss;
    rf_addr_t waddr, iaddr;
    rf_data_t wdata;
    rf_addr_t rs_addr [4];
    rf_addr_t rs_addr_n [2];
    rf_data_t m_data [4];
    rf_data_t n_data [2];
    logic [3:0] m_busy;
    logic [1:0] n_busy;
    int errors = 0;
    int checks = 0;

    typedef struct {
        string    tag;
        int       sel;
        int       port;
        rf_data_t data;
        logic     busy;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    assign rs_addr_n[0] = rs_addr[0];
    assign rs_addr_n[1] = rs_addr[1];

    reg_file_mp #(.NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u_m (
        .clk_i(clk), .rst_i(rst), .rd_wren_i(wren), .rd_addr_i(waddr), .rd_data_i(wdata),
        .iss_valid_i(iss), .iss_addr_i(iaddr), .rs_addr_i(rs_addr),
        .rs_data_o(m_data), .rs_busy_o(m_busy)
    );

    reg_file_mp #(.NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u_n (
        .clk_i(clk), .rst_i(rst), .rd_wren_i(wren), .rd_addr_i(waddr), .rd_data_i(wdata),
        .iss_valid_i(iss), .iss_addr_i(iaddr), .rs_addr_i(rs_addr_n),
        .rs_data_o(n_data), .rs_busy_o(n_busy)
    );

    task automatic drv(input logic r, input logic we, input rf_addr_t wa, input rf_data_t wd,
                       input logic iv, input rf_addr_t ia,
                       input rf_addr_t a0, input rf_addr_t a1, input rf_addr_t a2, input rf_addr_t a3);
        rst = r; wren = we; waddr = wa; wdata = wd; iss = iv; iaddr = ia;
        rs_addr[0] = a0; rs_addr[1] = a1; rs_addr[2] = a2; rs_addr[3] = a3;
    endtask

    task automatic exp_rd(input string tag, input int sel, input int port, input rf_data_t d, input logic b);
        exp_t e;
        e.tag = tag; e.sel = sel; e.port = port; e.data = d; e.busy = b;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        rf_data_t od;
        logic ob;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            od = (e.sel == 0) ? m_data[e.port] : n_data[e.port[0]];
            ob = (e.sel == 0) ? m_busy[e.port] : n_busy[e.port[0]];
            checks++;
            assert (od === e.data) else begin
                errors++;
                $error("FAIL %s dut%0d p%0d data obs=%h exp=%h", e.tag, e.sel, e.port, od, e.data);
            end
            checks++;
            assert (ob === e.busy) else begin
                errors++;
                $error("FAIL %s dut%0d p%0d busy obs=%b exp=%b", e.tag, e.sel, e.port, ob, e.busy);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        drv(0, 1, 2, 32'h44444444, 0, 0, 2, 2, 0, 0);
        exp_rd("pre_rst_wr", 0, 0, 32'h44444444, 0);
        exp_rd("pre_rst_wr", 0, 1, 32'h44444444, 0);
        exp_rd("pre_rst_wr", 1, 0, 32'h00000000, 0);
        cyc();
        drv(1, 1, 2, 32'h99999999, 1, 2, 2, 2, 0, 0);
        exp_rd("in_rst", 0, 0, 32'h99999999, 0);
        exp_rd("in_rst", 1, 0, 32'h44444444, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 2, 2, 0, 0);
        exp_rd("post_rst", 0, 0, 32'h0, 0);
        exp_rd("post_rst", 0, 1, 32'h0, 0);
        exp_rd("post_rst", 1, 0, 32'h0, 0);
        exp_rd("post_rst", 1, 1, 32'h0, 0);
        cyc();
        drv(0, 1, 2, 32'h44444444, 0, 0, 2, 0, 0, 0);
        exp_rd("wr_x2", 0, 0, 32'h44444444, 0);
        exp_rd("wr_x2", 1, 0, 32'h0, 0);
        cyc();
        drv(0, 1, 1, 32'h12345678, 0, 0, 1, 2, 0, 0);
        exp_rd("wr_x1", 0, 0, 32'h12345678, 0);
        exp_rd("wr_x1", 0, 1, 32'h44444444, 0);
        exp_rd("wr_x1", 1, 0, 32'h0, 0);
        exp_rd("wr_x1", 1, 1, 32'h44444444, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        exp_rd("rd_x1_x2", 0, 0, 32'h12345678, 0);
        exp_rd("rd_x1_x2", 0, 1, 32'h44444444, 0);
        exp_rd("rd_x1_x2", 1, 0, 32'h12345678, 0);
        exp_rd("rd_x1_x2", 1, 1, 32'h44444444, 0);
        cyc();
        drv(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 5, 0, 0);
        exp_rd("wr_x0", 0, 0, 32'h0, 0);
        exp_rd("wr_x0", 1, 0, 32'h0, 0);
        exp_rd("wr_x0", 1, 1, 32'h0, 0);
        cyc();
        drv(0, 1, 5, 32'hFFFFFFFF, 0, 0, 0, 5, 0, 0);
        exp_rd("byp_x5", 0, 0, 32'h0, 0);
        exp_rd("byp_x5", 0, 1, 32'hFFFFFFFF, 0);
        exp_rd("byp_x5", 1, 0, 32'hFFFFFFFF, 0);
        exp_rd("byp_x5", 1, 1, 32'h0, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 1, 2, 5, 0);
        exp_rd("four_port", 0, 0, 32'h12345678, 0);
        exp_rd("four_port", 0, 1, 32'h44444444, 0);
        exp_rd("four_port", 0, 2, 32'hFFFFFFFF, 0);
        exp_rd("four_port", 0, 3, 32'h0, 0);
        exp_rd("four_port", 1, 0, 32'h12345678, 0);
        exp_rd("four_port", 1, 1, 32'h44444444, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
        exp_rd("late_x5", 1, 0, 32'hFFFFFFFF, 0);
        exp_rd("late_x5", 1, 1, 32'hFFFFFFFF, 0);
        cyc();
        drv(0, 0, 0, 0, 1, 7, 7, 7, 0, 0);
        exp_rd("iss_x7", 0, 0, 32'h0, 0);
        exp_rd("iss_x7", 1, 0, 32'h0, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 7, 7, 0, 0);
        exp_rd("busy_x7", 0, 0, 32'h0, 1);
        exp_rd("busy_x7", 0, 1, 32'h0, 1);
        exp_rd("busy_x7", 1, 0, 32'h0, 1);
        cyc();
        drv(0, 1, 7, 32'hA5A5A5A5, 0, 0, 7, 0, 0, 0);
        exp_rd("wb_x7", 0, 0, 32'hA5A5A5A5, 0);
        exp_rd("wb_x7", 1, 0, 32'h0, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 7, 0, 0, 0);
        exp_rd("after_wb", 0, 0, 32'hA5A5A5A5, 0);
        exp_rd("after_wb", 1, 0, 32'hA5A5A5A5, 0);
        cyc();
        drv(0, 0, 0, 0, 1, 7, 7, 0, 0, 0);
        exp_rd("reiss_x7", 0, 0, 32'hA5A5A5A5, 0);
        exp_rd("reiss_x7", 1, 0, 32'hA5A5A5A5, 0);
        cyc();
        drv(0, 1, 7, 32'h5A5A5A5A, 1, 7, 7, 0, 0, 0);
        exp_rd("iss_and_wb", 0, 0, 32'h5A5A5A5A, 0);
        exp_rd("iss_and_wb", 1, 0, 32'hA5A5A5A5, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 7, 0, 0, 0);
        exp_rd("set_wins", 0, 0, 32'h5A5A5A5A, 1);
        exp_rd("set_wins", 1, 0, 32'h5A5A5A5A, 1);
        cyc();
        drv(0, 0, 0, 0, 1, 0, 0, 5, 0, 0);
        exp_rd("iss_x0", 0, 0, 32'h0, 0);
        exp_rd("iss_x0", 1, 0, 32'hFFFFFFFF, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
        exp_rd("busy_x0", 0, 0, 32'h0, 0);
        exp_rd("busy_x0", 0, 1, 32'h5A5A5A5A, 1);
        exp_rd("busy_x0", 1, 0, 32'hFFFFFFFF, 1);
        cyc();
        drv(1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        exp_rd("mid_rst", 0, 0, 32'h5A5A5A5A, 1);
        exp_rd("mid_rst", 1, 1, 32'h12345678, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 7, 1, 5, 0);
        exp_rd("after_mid_rst", 0, 0, 32'h0, 0);
        exp_rd("after_mid_rst", 0, 1, 32'h0, 0);
        exp_rd("after_mid_rst", 0, 2, 32'h0, 0);
        exp_rd("after_mid_rst", 0, 3, 32'h0, 0);
        exp_rd("after_mid_rst", 1, 0, 32'h0, 0);
        exp_rd("after_mid_rst", 1, 1, 32'h0, 0);
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port integer register file with write-to-read bypass, hardwired zero register and a per-register pending-write scoreboard. Successor to the fixed 32x32, two-read-port `reg_file`. Sits between decode (read ports, issue marking) and writeback (write port) of the pipelined core. Lets decode read operands and detect RAW hazards on in-flight producers in one place.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2**ADDR_W
- `NUM_RD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, 1 = register 0 reads 0, ignores writes, never busy
- `BYPASS`, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- `clk_i` in 1, single clock, all state on rising edge
- `rst_i` in 1, reset; **synchronous, active-high**
- `rd_wren_i` in 1, writeback enable
- `rd_addr_i` in ADDR_W, writeback address
- `rd_data_i` in DATA_W, writeback data
- `iss_valid_i` in 1, decode issued an instruction that will write `iss_addr_i`
- `iss_addr_i` in ADDR_W, destination of issued instruction
- `rs_addr_i` in NUM_RD x ADDR_W, read addresses (unpacked array)
- `rs_data_o` out NUM_RD x DATA_W, read data
- `rs_busy_o` out NUM_RD, read register has a pending, not yet forwarded, write

## Operation
- Storage: 2**ADDR_W x DATA_W flops, plus `busy` vector of 2**ADDR_W bits.
- Write: at edge, if `rd_wren_i` and not (ZERO_REG and `rd_addr_i`==0), `mem[rd_addr_i] <= rd_data_i`.
- Read (combinational, per port p):
  - ZERO_REG and `rs_addr_i[p]`==0 -> 0.
  - Else BYPASS and `rd_wren_i` and `rd_addr_i`==`rs_addr_i[p]` -> `rd_data_i`.
  - Else `mem[rs_addr_i[p]]`.
- Scoreboard, evaluated per edge:
  - `rd_wren_i` clears `busy[rd_addr_i]`.
  - `iss_valid_i` sets `busy[iss_addr_i]`.
  - Same address both: set wins (newer producer outstanding).
  - Address 0 with ZERO_REG: never set.
- `rs_busy_o[p]` = `busy[rs_addr_i[p]]`, masked to 0 when BYPASS and the same-cycle write matches, since data is already forwarded. Always 0 for address 0 with ZERO_REG.
- Multiple read ports may share an address. No read-port conflicts.

## Timing
- Reset: at an edge with `rst_i`=1, all `mem` entries <= 0 and all `busy` <= 0. Writes and issues in that cycle are dropped. After reset every `rs_data_o` = 0 and `rs_busy_o` = 0.
- Reset asserted mid-operation behaves identically; no partial state survives.
- Write latency:
  - BYPASS=1: visible on reads in the same cycle, combinationally.
  - BYPASS=0: visible from the cycle after the edge.
- Busy latency: set is visible from the cycle after the issue edge. Clear is visible the cycle after the writeback edge, or in the same cycle via the bypass mask.
- Writeback to a register not busy is legal and writes normally.
- Issue to a register already busy is legal (WAW) and stays set.
- No combinational path from `iss_*` to outputs.

## Structure
- Shared package `rf_pkg`: `DATA_W`/`ADDR_W` defaults, `rf_addr_t`, `rf_data_t` typedefs.
- Sub-module `rf_scoreboard`: busy vector, set/clear priority, per-port busy lookup with bypass mask.
- Storage and read muxing live in the top module.

## Test plan
- Reset then read: `rst_i`=1 for one edge after writing 0x44444444 to x2; read x2 on both ports -> 0x00000000, busy 0.
- Write/read, two ports: write x2=0x44444444, then x1=0x12345678; read p0=x1, p1=x2 next cycle -> 0x12345678 / 0x44444444.
- Zero register: write x0=0xFFFFFFFF with ZERO_REG=1 -> reads 0. With ZERO_REG=0, reads 0xFFFFFFFF the next cycle.
- Bypass: same cycle write x5=0xFFFFFFFF and read x5 -> 0xFFFFFFFF in that cycle when BYPASS=1. With BYPASS=0, old value 0 that cycle and 0xFFFFFFFF the next.
- Scoreboard: issue x7 -> `rs_busy_o`=1 reading x7 from the next cycle. Writeback x7=0xA5A5A5A5 -> busy masked and data forwarded that cycle, busy 0 after. Issue and writeback of x7 in the same cycle -> busy stays 1.
- NUM_RD=4: four ports read x1, x2, x5, x0 simultaneously -> 0x12345678, 0x44444444, 0xFFFFFFFF, 0.
